// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array front end.
// Provides default element width and matrix dimension, the per-bank
// occupancy enum, and the row/col counter width helper.
package systolic_pkg;

   localparam int unsigned DefWidth = 4;
   localparam int unsigned DefSize  = 3;

   typedef enum logic [1:0] {
      BankEmpty,
      BankFilling,
      BankFull
   } bank_state_e;

   // Counter width is $clog2(size); a 1x1 matrix still needs a 1-bit index.
   function automatic int unsigned cnt_width(input int unsigned size);
      return (size > 1) ? $clog2(size) : 1;
   endfunction

endpackage

// File: rtl/matrix_bank.sv
// One SIZE x SIZE element register array.
// Ports:
//   clock  - rising-edge clock
//   clear  - synchronous clear of all elements to zero (has priority)
//   we     - write enable for the element at [row][col]
//   row    - row index of the write
//   col    - column index of the write
//   wdata  - element written
//   data   - full array contents, index [row][col]
module matrix_bank
   import systolic_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned SIZE  = DefSize,
   parameter int unsigned CNT_W = cnt_width(SIZE)
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             we,
   input  logic [CNT_W-1:0] row,
   input  logic [CNT_W-1:0] col,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] data [SIZE][SIZE]
);

   logic [WIDTH-1:0] mem_q [SIZE][SIZE];

   always_ff @(posedge clock) begin
      if (clear) begin
         for (int r = 0; r < int'(SIZE); r++) begin
            for (int c = 0; c < int'(SIZE); c++) begin
               mem_q[r][c] <= '0;
            end
         end
      end else if (we) begin
         for (int r = 0; r < int'(SIZE); r++) begin
            for (int c = 0; c < int'(SIZE); c++) begin
               if (row == CNT_W'(r) && col == CNT_W'(c)) begin
                  mem_q[r][c] <= wdata;
               end
            end
         end
      end
   end

   assign data = mem_q;

endmodule

// File: rtl/matrix_loader.sv
// Ping-pong matrix loader: assembles a row-major element stream into
// SIZE x SIZE matrices and hands them to the downstream skew stage.
// Ports:
//   clock, reset         - rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    - element handshake; in_data is the element,
//                          in_last marks the final element of a matrix
//   mat_valid/mat_ready  - matrix handshake; mat_data is [row][col]
//   err                  - sticky framing error (bad in_last placement)
module matrix_loader
   import systolic_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned SIZE  = DefSize
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             mat_valid,
   input  logic             mat_ready,
   output logic [WIDTH-1:0] mat_data [SIZE][SIZE],
   output logic             err
);

   localparam int unsigned    CntW    = cnt_width(SIZE);
   localparam logic [CntW-1:0] LastIdx = CntW'(SIZE - 1);

   bank_state_e [1:0] state_q, state_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   row_q, row_d;
   logic [CntW-1:0]   col_q, col_d;
   logic              err_q, err_d;

   logic       push;
   logic       pop;
   logic       last_elem;
   logic [1:0] bank_we;

   logic [WIDTH-1:0] bank0_data [SIZE][SIZE];
   logic [WIDTH-1:0] bank1_data [SIZE][SIZE];

   assign in_ready  = (state_q[wr_ptr_q] != BankFull);
   assign mat_valid = (state_q[rd_ptr_q] == BankFull);
   assign err       = err_q;

   assign push      = in_valid & in_ready;
   assign pop       = mat_valid & mat_ready;
   assign last_elem = (row_q == LastIdx) && (col_q == LastIdx);

   // Release and completion always target different banks (the read bank is
   // FULL, the write bank is not), so both updates can be applied together.
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      row_d    = row_q;
      col_d    = col_q;
      err_d    = err_q;
      bank_we  = '0;

      if (pop) begin
         state_d[rd_ptr_q] = BankEmpty;
         rd_ptr_d          = ~rd_ptr_q;
      end

      if (push) begin
         bank_we[wr_ptr_q] = 1'b1;
         if (last_elem) begin
            // Commit even if in_last is missing; flag the framing slip.
            state_d[wr_ptr_q] = BankFull;
            wr_ptr_d          = ~wr_ptr_q;
            row_d             = '0;
            col_d             = '0;
            if (!in_last) begin
               err_d = 1'b1;
            end
         end else if (in_last) begin
            // Early in_last: drop the partial matrix and restart at [0][0].
            state_d[wr_ptr_q] = BankEmpty;
            row_d             = '0;
            col_d             = '0;
            err_d             = 1'b1;
         end else begin
            state_d[wr_ptr_q] = BankFilling;
            if (col_q == LastIdx) begin
               col_d = '0;
               row_d = row_q + CntW'(1);
            end else begin
               col_d = col_q + CntW'(1);
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= {BankEmpty, BankEmpty};
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         row_q    <= '0;
         col_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         row_q    <= row_d;
         col_q    <= col_d;
         err_q    <= err_d;
      end
   end

   matrix_bank #(
      .WIDTH (WIDTH),
      .SIZE  (SIZE),
      .CNT_W (CntW)
   ) u_bank0 (
      .clock (clock),
      .clear (reset),
      .we    (bank_we[0]),
      .row   (row_q),
      .col   (col_q),
      .wdata (in_data),
      .data  (bank0_data)
   );

   matrix_bank #(
      .WIDTH (WIDTH),
      .SIZE  (SIZE),
      .CNT_W (CntW)
   ) u_bank1 (
      .clock (clock),
      .clear (reset),
      .we    (bank_we[1]),
      .row   (row_q),
      .col   (col_q),
      .wdata (in_data),
      .data  (bank1_data)
   );

   always_comb begin
      for (int r = 0; r < int'(SIZE); r++) begin
         for (int c = 0; c < int'(SIZE); c++) begin
            mat_data[r][c] = rd_ptr_q ? bank1_data[r][c] : bank0_data[r][c];
         end
      end
   end

endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader (WIDTH=4, SIZE=3).
// A queue-based reference model (partial element list + queue of completed
// matrices, capacity two) is compared against the DUT after every clock.
module tb_matrix_loader;

   localparam int W = 4;
   localparam int S = 3;
   localparam int N = S * S;

   logic         clock = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         in_last;
   logic         mat_valid;
   logic         mat_ready;
   logic [W-1:0] mat_data [S][S];
   logic         err;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state.
   logic [W-1:0]   m_part [$];
   logic [N*W-1:0] m_done [$];
   logic           m_err;

   typedef struct packed {
      logic           rst;
      logic           vld;
      logic [W-1:0]   dat;
      logic           lst;
      logic           mrdy;
      logic           e_ir;
      logic           e_mv;
      logic           e_err;
      logic           chk;
      logic [N*W-1:0] e_mat;
   } vec_t;

   vec_t vecs [16];

   matrix_loader #(
      .WIDTH (W),
      .SIZE  (S)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .mat_valid (mat_valid),
      .mat_ready (mat_ready),
      .mat_data  (mat_data),
      .err       (err)
   );

   always #5 clock = ~clock;

   function automatic logic [N*W-1:0] dut_mat();
      logic [N*W-1:0] m;
      m = '0;
      for (int r = 0; r < S; r++) begin
         for (int c = 0; c < S; c++) begin
            m[(r*S+c)*W +: W] = mat_data[r][c];
         end
      end
      return m;
   endfunction

   // Matrix whose k-th row-major element is (start+k) mod 16.
   function automatic logic [N*W-1:0] seq_mat(input int start);
      logic [N*W-1:0] m;
      for (int k = 0; k < N; k++) begin
         m[k*W +: W] = W'((start + k) % 16);
      end
      return m;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input logic r, input logic v, input logic [W-1:0] d,
                             input logic l, input logic mr);
      bit             rel;
      bit             acc;
      logic [N*W-1:0] m;
      if (r) begin
         m_part.delete();
         m_done.delete();
         m_err = 1'b0;
      end else begin
         rel = (m_done.size() > 0) && mr;
         acc = v && (m_done.size() < 2);
         if (rel) void'(m_done.pop_front());
         if (acc) begin
            m_part.push_back(d);
            if (m_part.size() == N) begin
               for (int k = 0; k < N; k++) m[k*W +: W] = m_part[k];
               m_done.push_back(m);
               m_part.delete();
               if (!l) m_err = 1'b1;
            end else if (l) begin
               m_part.delete();
               m_err = 1'b1;
            end
         end
      end
   endtask

   task automatic compare_model();
      check("model in_ready", in_ready, m_done.size() < 2);
      check("model mat_valid", mat_valid, m_done.size() > 0);
      check("model err", err, m_err);
      if (m_done.size() > 0) check("model mat_data", dut_mat(), m_done[0]);
   endtask

   // Drive inputs, advance one edge, then compare against the model.
   task automatic cycle(input logic r, input logic v, input logic [W-1:0] d,
                        input logic l, input logic mr);
      reset     = r;
      in_valid  = v;
      in_data   = d;
      in_last   = l;
      mat_ready = mr;
      model_step(r, v, d, l, mr);
      @(posedge clock);
      #1;
      compare_model();
   endtask

   function automatic vec_t mk(input logic rst, input logic vld, input logic [W-1:0] dat,
                               input logic lst, input logic mrdy, input logic e_ir,
                               input logic e_mv, input logic chk, input logic [N*W-1:0] e_mat);
      vec_t v;
      v.rst   = rst;
      v.vld   = vld;
      v.dat   = dat;
      v.lst   = lst;
      v.mrdy  = mrdy;
      v.e_ir  = e_ir;
      v.e_mv  = e_mv;
      v.e_err = 1'b0;
      v.chk   = chk;
      v.e_mat = e_mat;
      return v;
   endfunction

   initial begin
      logic nat_last;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      mat_ready = 1'b0;
      m_err     = 1'b0;

      // Reset, 4 elements, reset mid-load, then a clean 1..9 matrix.
      vecs[0] = mk(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, '0);
      for (int i = 1; i <= 4; i++) begin
         vecs[i] = mk(1'b0, 1'b1, W'(i), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
      end
      vecs[5] = mk(1'b1, 1'b1, 4'h7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, '0);
      for (int i = 6; i <= 14; i++) begin
         vecs[i] = mk(1'b0, 1'b1, W'(i - 5), (i == 14), 1'b1, 1'b1, (i == 14), (i == 14),
                      seq_mat(1));
      end
      vecs[15] = mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);

      for (int i = 0; i < 16; i++) begin
         cycle(vecs[i].rst, vecs[i].vld, vecs[i].dat, vecs[i].lst, vecs[i].mrdy);
         check($sformatf("vec%0d in_ready", i), in_ready, vecs[i].e_ir);
         check($sformatf("vec%0d mat_valid", i), mat_valid, vecs[i].e_mv);
         check($sformatf("vec%0d err", i), err, vecs[i].e_err);
         if (vecs[i].chk) check($sformatf("vec%0d mat_data", i), dut_mat(), vecs[i].e_mat);
      end

      // 27 back-to-back elements with the downstream stalled.
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
      for (int i = 1; i <= 18; i++) begin
         cycle(1'b0, 1'b1, W'(i % 16), (i % N == 0), 1'b0);
      end
      check("stall in_ready", in_ready, 1'b0);
      check("stall mat_valid", mat_valid, 1'b1);
      check("stall first matrix", dut_mat(), seq_mat(1));
      for (int i = 0; i < 2; i++) begin
         cycle(1'b0, 1'b1, W'(19 % 16), 1'b0, 1'b0);
         check("stall hold valid", mat_valid, 1'b1);
         check("stall hold data", dut_mat(), seq_mat(1));
      end
      cycle(1'b0, 1'b1, W'(19 % 16), 1'b0, 1'b1);
      check("unstall mat_valid", mat_valid, 1'b1);
      check("unstall second matrix", dut_mat(), seq_mat(10));
      check("unstall in_ready", in_ready, 1'b1);
      for (int i = 19; i <= 27; i++) begin
         cycle(1'b0, 1'b1, W'(i % 16), (i == 27), 1'b1);
      end
      check("third matrix", dut_mat(), seq_mat(19));
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
      check("drained mat_valid", mat_valid, 1'b0);

      // Early in_last on 5th element, then a full matrix A..2.
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) cycle(1'b0, 1'b1, W'(i), (i == 5), 1'b0);
      check("early last err", err, 1'b1);
      check("early last no valid", mat_valid, 1'b0);
      for (int k = 0; k < N; k++) cycle(1'b0, 1'b1, W'((10 + k) % 16), (k == N - 1), 1'b0);
      check("after discard valid", mat_valid, 1'b1);
      check("after discard matrix", dut_mat(), seq_mat(10));
      check("err sticky", err, 1'b1);
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);

      // Completion of bank1 coinciding with release of bank0.
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
      for (int k = 0; k < N; k++) cycle(1'b0, 1'b1, W'(1 + k), (k == N - 1), 1'b0);
      for (int k = 0; k < N - 1; k++) cycle(1'b0, 1'b1, W'(3 + k), 1'b0, 1'b0);
      check("pre-overlap in_ready", in_ready, 1'b1);
      check("pre-overlap bank0", dut_mat(), seq_mat(1));
      cycle(1'b0, 1'b1, W'(3 + N - 1), 1'b1, 1'b1);
      check("overlap mat_valid", mat_valid, 1'b1);
      check("overlap bank1", dut_mat(), seq_mat(3));
      check("overlap in_ready", in_ready, 1'b1);
      check("overlap err", err, 1'b0);
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
      check("overlap drained", mat_valid, 1'b0);

      // Randomised traffic against the model.
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 4000; i++) begin
         nat_last = (m_part.size() == N - 1);
         cycle(($urandom_range(0, 299) == 0),
               ($urandom_range(0, 9) < 7),
               W'($urandom),
               ($urandom_range(0, 29) == 0) ? ~nat_last : nat_last,
               ($urandom_range(0, 1) == 1));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 4, element bit width.
REQ-002 SHALL have parameter SIZE, default 3, matrix dimension (SIZE x SIZE).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  element present on in_data.
REQ-006 SHALL have port in_ready  output  1  loader can accept an element this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  matrix element, row-major order.
REQ-008 SHALL have port in_last  input  1  producer marks final element of a matrix.
REQ-009 SHALL have port mat_valid  output  1  complete matrix on mat_data.
REQ-010 SHALL have port mat_ready  input  1  downstream skew stage accepts the matrix.
REQ-011 SHALL have port mat_data  output  WIDTH x [SIZE][SIZE] unpacked  assembled matrix, index [row][col], the format the downstream skew stage consumes.
REQ-012 SHALL have port err  output  1  sticky framing-error flag.

Function
REQ-013 SHALL hold two SIZE x SIZE banks (ping-pong), each tracked EMPTY/FILLING/FULL.
REQ-014 SHALL transfer an element only on a cycle with in_valid=1 and in_ready=1.
REQ-015 SHALL drive in_ready=1 iff the write bank (wr_ptr) is not FULL.
REQ-016 SHALL write the k-th accepted element (k=0..SIZE*SIZE-1) to bank[wr_ptr][k/SIZE][k%SIZE] using row/col counters; col wraps at SIZE-1 and increments row.
REQ-017 SHALL, on acceptance of element k=SIZE*SIZE-1, mark the bank FULL, toggle wr_ptr, and clear row/col to 0.
REQ-018 SHALL drive mat_valid=1 iff bank[rd_ptr] is FULL; mat_data = bank[rd_ptr] contents, combinationally selected.
REQ-019 SHALL assert mat_valid on the cycle after the last element is accepted (latency 1).
REQ-020 SHALL, on mat_valid=1 and mat_ready=1, mark bank[rd_ptr] EMPTY and toggle rd_ptr.
REQ-021 SHALL hold mat_data and mat_valid stable while mat_valid=1 and mat_ready=0.
REQ-022 SHALL apply completion of one bank and release of the other in the same cycle independently, with both effects visible next cycle.
REQ-023 SHALL sustain one element per clock when mat_ready keeps pace (no bubble between matrices).
REQ-024 SHALL, if in_last=1 on an accepted element with k<SIZE*SIZE-1, write the element, set err, discard the partial matrix (bank stays not-FULL, row/col cleared to 0).
REQ-025 SHALL, if element k=SIZE*SIZE-1 is accepted with in_last=0, set err and still commit the matrix.
REQ-026 SHALL keep err at 1 until reset.

Reset
REQ-027 SHALL, when reset=1 at a clock edge, clear both banks to EMPTY with zero contents, wr_ptr=rd_ptr=0, row=col=0, err=0, regardless of in-progress load.
REQ-028 SHALL present mat_valid=0, in_ready=1, err=0, mat_data all zero in the cycle after reset.
REQ-029 SHALL ignore in_valid and mat_ready in any cycle where reset=1.

Structure
REQ-030 SHALL take WIDTH/SIZE defaults, the bank-state enum (EMPTY/FILLING/FULL) and the counter width $clog2(SIZE) from shared package systolic_pkg.
REQ-031 SHALL instantiate sub-module matrix_bank twice: one SIZE x SIZE register array with write enable, row/col index, synchronous clear.

Verification
REQ-032 SHALL cover: load 1..9, in_last on 9th, mat_ready=1 -> mat_valid=1 for one cycle, the cycle after 9th; mat_data rows {1,2,3},{4,5,6},{7,8,9}; err=0.
REQ-033 SHALL cover: 27 back-to-back elements, mat_ready=0 -> in_ready=0 after 18th acceptance; mat_data = first matrix; raise mat_ready -> second matrix next cycle, in_ready=1.
REQ-034 SHALL cover: in_last on 5th element -> err=1, no mat_valid; following 9 elements 0xA..0x2 (wrapping) form a full matrix at [0][0]..[2][2].
REQ-035 SHALL cover: bank0 FULL, 9th element of bank1 accepted in the same cycle mat_ready=1 -> next cycle mat_valid=1 showing bank1, in_ready=1.
REQ-036 SHALL cover: reset=1 after 4 accepted elements -> mat_valid=0, err=0; next load 1..9 lands at [0][0]..[2][2] in bank0.
